sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT, default 2, SRAM cycles per half-word phase; legal range 2..15.
REQ-002 Parameter BASE, default 32'd1024, byte address mapped to SRAM word 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 MEM_R_EN  in  1  read request from MEM stage.
REQ-006 MEM_W_EN  in  1  write request from MEM stage.
REQ-007 adr  in  32  byte address (ALU result).
REQ-008 data_in  in  32  write data (Rm value).
REQ-009 ready  out  1  high = access complete / no access pending; low = pipeline freeze.
REQ-010 DATA  out  32  registered read data.
REQ-011 SRAM_ADDR  out  18  half-word address to SRAM.
REQ-012 SRAM_DQ_out  out  16  write half-word.
REQ-013 SRAM_DQ_in  in  16  read half-word.
REQ-014 SRAM_DQ_oe  out  1  high = controller drives DQ.
REQ-015 SRAM_WE_N  out  1  active-low write strobe.

Function
REQ-016 FSM states: IDLE, LO, HI, FIN; 4-bit phase counter cnt.
REQ-017 IDLE with MEM_R_EN or MEM_W_EN high: latch adr, data_in and op; cnt<=0; next LO.
REQ-018 Both enables high: write; read ignored.
REQ-019 Word index w = (adr_latched - BASE) >> 2, truncated to 17 bits; SRAM_ADDR = {w, 1'b0} in LO, {w, 1'b1} in HI; 0 in IDLE/FIN.
REQ-020 LO/HI: cnt increments each cycle; at cnt == WAIT-1, cnt<=0 and advance LO->HI, HI->FIN.
REQ-021 FIN: one cycle, then IDLE unconditionally.
REQ-022 ready = 1 in FIN, and in IDLE when neither enable is high; 0 otherwise (combinational from state and enables).
REQ-023 Latency: from the IDLE cycle with a request, ready stays low 1+2*WAIT cycles and is high in the following (FIN) cycle; WAIT=2 gives 5 low, 1 high.
REQ-024 Read: SRAM_DQ_in sampled at cnt == WAIT-1 into DATA[15:0] in LO and into DATA[31:16] in HI.
REQ-025 DATA holds its value until the next read updates it; writes never change DATA.
REQ-026 Write: SRAM_DQ_oe = 1 throughout LO and HI; SRAM_DQ_out = data[15:0] in LO, data[31:16] in HI; 0 elsewhere.
REQ-027 Write: SRAM_WE_N = 0 for cnt 0..WAIT-2 in LO and HI; 1 at cnt == WAIT-1 so address and data are stable at the strobe rising edge.
REQ-028 Read: SRAM_WE_N = 1 and SRAM_DQ_oe = 0 in all states.
REQ-029 Input changes while not IDLE are ignored; the latched operation completes.
REQ-030 A request present in the FIN cycle is not started; it starts in the following IDLE cycle.
REQ-031 Back-to-back requests: a new access starts every 2+2*WAIT cycles.

Reset
REQ-032 rst high at a clock edge: state IDLE, cnt 0, DATA 0, latches 0; SRAM_WE_N 1, SRAM_DQ_oe 0, SRAM_ADDR 0, SRAM_DQ_out 0.
REQ-033 rst has priority over every transition, including mid-LO/HI; the aborted access never reaches FIN and ready does not pulse high for it.
REQ-034 Following the first rst-low edge, the controller accepts a request in IDLE normally.

Verification
REQ-035 WAIT=2, write adr=1024+8, data_in=32'hDEAD_BEEF -> SRAM_ADDR 4 then 5; DQ_out 16'hBEEF then 16'hDEAD; WE_N 0,1,0,1; ready low 5 cycles, high on the 6th.
REQ-036 Read adr=1032 with SRAM model returning 16'hBEEF/16'hDEAD -> DATA=32'hDEAD_BEEF in the FIN cycle; WE_N stays 1, DQ_oe stays 0.
REQ-037 MEM_R_EN and MEM_W_EN both high, data_in=32'h1234_5678 -> write performed; DATA unchanged.
REQ-038 rst asserted in HI of a write -> next cycle IDLE, WE_N 1, DQ_oe 0, DATA 0, no ready pulse; the next read completes normally.
REQ-039 Back-to-back reads at 1024 then 1028 with request held through FIN -> second access starts in the IDLE cycle after FIN; SRAM_ADDR 0,1 then 2,3; period 6 cycles.
REQ-040 WAIT=4 single read -> ready low 9 cycles; SRAM_DQ_in sampled only at cnt=3 of each phase.

Source files
------------

// File: rtl/sram_ctrl.sv
// Purpose : splits 32-bit MEM-stage loads/stores into two half-word SRAM accesses (low half, then high half).
// Latency : ready low for 1+2*WAIT cycles from the accepting IDLE cycle, high in the FIN cycle; a new access every 2+2*WAIT cycles.
// Backpr. : ready low freezes the pipeline; inputs are ignored while busy, and a request seen in FIN waits for the next IDLE cycle.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN       read / write request (a write wins when both are high)
//   adr, data_in             byte address and write data, latched when the request is accepted
//   ready, DATA              access complete / idle flag; registered read data
//   SRAM_ADDR                half-word address: {word, 0} during LO, {word, 1} during HI
//   SRAM_DQ_out/_in/_oe      half-word data bus split into out, in and output enable
//   SRAM_WE_N                active-low write strobe
module sram_ctrl #(
  parameter int          WAIT = 2,
  parameter logic [31:0] BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] adr,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic [31:0] DATA,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        wr_q;
  logic        req;
  logic        last;
  logic [16:0] word;

  assign req  = MEM_R_EN | MEM_W_EN;
  assign last = (cnt == CNT_LAST);
  // Word index relative to the mapped base; the top address bits are
  // deliberately dropped, the SRAM only spans 2^17 words.
  assign word = 17'((adr_q - BASE) >> 2);

  // Next state and all SRAM-side outputs
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    SRAM_ADDR   = 18'd0;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = 4'd0;
        end
      end
      LO, HI: begin
        SRAM_ADDR = {word, (state == HI)};
        if (wr_q) begin
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = (state == HI) ? dat_q[31:16] : dat_q[15:0];
          // Strobe rises on the last phase cycle so address and data are
          // already stable at the rising edge.
          SRAM_WE_N   = last;
        end
        if (last) begin
          cnt_nxt   = 4'd0;
          state_nxt = (state == LO) ? HI : FIN;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      FIN: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      adr_q <= 32'd0;
      dat_q <= 32'd0;
      wr_q  <= 1'b0;
      DATA  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        adr_q <= adr;
        dat_q <= data_in;
        wr_q  <= MEM_W_EN;
      end
      // Read data is taken at the end of each phase, after WAIT cycles of
      // SRAM access time.
      if (!wr_q && last) begin
        if (state == LO) DATA[15:0]  <= SRAM_DQ_in;
        if (state == HI) DATA[31:16] <= SRAM_DQ_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose : self-checking bench for sram_ctrl (WAIT=2 main instance, WAIT=4 latency instance).
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_sram_ctrl;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_en, w_en;
  logic [31:0] adr, data_in;
  logic        ready;
  logic [31:0] data_out;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, we_n;

  logic        r4, w4;
  logic [31:0] adr4, d4;
  logic        ready4;
  logic [31:0] data4;
  logic [17:0] sram_addr4;
  logic [15:0] dq_out4, dq_in4;
  logic        dq_oe4, we_n4;

  // Behavioural SRAM contents as seen by the reference model
  logic [15:0] mem [0:255];
  assign dq_in = mem[sram_addr[7:0]];

  sram_ctrl #(.WAIT(W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .adr(adr), .data_in(data_in),
    .ready(ready), .DATA(data_out), .SRAM_ADDR(sram_addr), .SRAM_DQ_out(dq_out),
    .SRAM_DQ_in(dq_in), .SRAM_DQ_oe(dq_oe), .SRAM_WE_N(we_n)
  );

  sram_ctrl #(.WAIT(4), .BASE(BASE)) dut4 (
    .clk(clk), .rst(rst), .MEM_R_EN(r4), .MEM_W_EN(w4), .adr(adr4), .data_in(d4),
    .ready(ready4), .DATA(data4), .SRAM_ADDR(sram_addr4), .SRAM_DQ_out(dq_out4),
    .SRAM_DQ_in(dq_in4), .SRAM_DQ_oe(dq_oe4), .SRAM_WE_N(we_n4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] data_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access on the WAIT=2 instance, starting in an IDLE cycle.
  // Expected waveforms come from the cycle index k within the access:
  // k=0 IDLE, k=1..W low phase, k=W+1..2W high phase, k=2W+1 FIN.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic fin_en, input logic [31:0] fin_adr);
    logic [16:0] w;
    logic [31:0] exp_data;
    int          ph, c;
    w        = 17'((a - BASE) >> 2);
    exp_data = wr ? data_model : {mem[{w[6:0], 1'b1}], mem[{w[6:0], 1'b0}]};
    r_en = rd; w_en = wr; adr = a; data_in = d;
    #1;
    chk("req_ready", 32'(ready), 0);
    chk("req_addr", 32'(sram_addr), 0);
    for (int k = 1; k <= 2 * W + 1; k++) begin
      step();
      if (k <= 2 * W) begin
        r_en = 1'($urandom); w_en = 1'($urandom); adr = $urandom; data_in = $urandom;
      end else begin
        r_en = fin_en; w_en = 1'b0; adr = fin_adr; data_in = $urandom;
      end
      #1;
      if (k <= 2 * W) begin
        ph = (k - 1) / W;
        c  = (k - 1) % W;
        chk("busy_ready", 32'(ready), 0);
        chk("addr", 32'(sram_addr), 32'({w, ph[0]}));
        chk("oe", 32'(dq_oe), 32'(wr));
        chk("dq_out", 32'(dq_out), wr ? 32'(ph ? d[31:16] : d[15:0]) : 32'd0);
        chk("we_n", 32'(we_n), (wr && c != W - 1) ? 32'd0 : 32'd1);
      end else begin
        chk("fin_ready", 32'(ready), 1);
        chk("fin_addr", 32'(sram_addr), 0);
        chk("fin_we_n", 32'(we_n), 1);
        chk("fin_oe", 32'(dq_oe), 0);
        chk("data", data_out, exp_data);
      end
    end
    if (wr) begin
      mem[{w[6:0], 1'b0}] = d[15:0];
      mem[{w[6:0], 1'b1}] = d[31:16];
    end else begin
      data_model = exp_data;
    end
    step();
  endtask

  initial begin
    logic [16:0] wm;
    logic [15:0] lo, hi;
    int          op;
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; adr = 32'd0; data_in = 32'd0;
    r4 = 1'b0; w4 = 1'b0; adr4 = 32'd0; d4 = 32'd0; dq_in4 = 16'd0;
    data_model = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    // Reset state
    step(); step();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_data", data_out, 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_oe", 32'(dq_oe), 0);
    chk("rst_dq_out", 32'(dq_out), 0);
    chk("rst_data4", data4, 0);
    rst = 1'b0;
    step();

    // Directed write then read-back of the same word
    run_access(1'b0, 1'b1, BASE + 8, 32'hDEAD_BEEF, 1'b0, 32'd0);
    run_access(1'b1, 1'b0, BASE + 8, 32'd0, 1'b0, 32'd0);
    chk("rd_deadbeef", data_out, 32'hDEAD_BEEF);

    // Both enables: write wins, DATA untouched
    run_access(1'b1, 1'b1, BASE + 16, 32'h1234_5678, 1'b0, 32'd0);
    chk("both_data_kept", data_out, 32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, BASE + 16, 32'd0, 1'b0, 32'd0);
    chk("both_readback", data_out, 32'h1234_5678);

    // Back-to-back reads, request held through FIN
    run_access(1'b1, 1'b0, BASE, $urandom, 1'b1, BASE + 4);
    run_access(1'b1, 1'b0, BASE + 4, $urandom, 1'b0, 32'd0);

    // Reset in the high phase of a write
    r_en = 1'b0; w_en = 1'b1; adr = BASE + 40; data_in = $urandom;
    #1;
    chk("abort_req_ready", 32'(ready), 0);
    for (int k = 1; k <= W + 1; k++) begin
      step();
      w_en = 1'b0;
      #1;
      chk("abort_busy_ready", 32'(ready), 0);
    end
    chk("abort_in_hi", 32'(sram_addr), 32'({17'd10, 1'b1}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    data_model = 32'd0;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_we_n", 32'(we_n), 1);
    chk("abort_oe", 32'(dq_oe), 0);
    chk("abort_data", data_out, 0);
    chk("abort_addr", 32'(sram_addr), 0);
    step();
    run_access(1'b1, 1'b0, BASE + 12, 32'd0, 1'b0, 32'd0);

    // Randomized accesses with optional idle gaps
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        r_en = 1'b0; w_en = 1'b0; adr = $urandom;
        #1;
        chk("idle_ready", 32'(ready), 1);
        step();
      end
      op = $urandom_range(0, 2);
      run_access(op != 1, op != 0, BASE + 4 * $urandom_range(0, 120), $urandom,
                 1'($urandom), $urandom);
    end

    // WAIT=4 read: input sampled only at the last cycle of each phase
    r_en = 1'b0; w_en = 1'b0;
    lo = 16'($urandom); hi = 16'($urandom);
    wm = 17'd5;
    r4 = 1'b1; adr4 = BASE + 20;
    #1;
    chk("w4_req_ready", 32'(ready4), 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      r4 = 1'b0; adr4 = $urandom;
      dq_in4 = (k == 4) ? lo : (k == 8) ? hi : (k < 4) ? ~lo : ~hi;
      #1;
      if (k <= 8) begin
        chk("w4_busy_ready", 32'(ready4), 0);
        chk("w4_addr", 32'(sram_addr4), 32'({wm, (k > 4)}));
        chk("w4_we_n", 32'(we_n4), 1);
      end else begin
        chk("w4_fin_ready", 32'(ready4), 1);
        chk("w4_data", data4, {hi, lo});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
